// File: rtl/me_sad_engine.sv
// Full-search 8x8 block-matching SAD motion estimator over a 16x16 window.
// Optional macro ME_EARLY_TERM_EN: stop the search on the first zero-SAD candidate.
module me_sad_engine #(
    parameter int PIX_W = 8,
    parameter int SAD_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*PIX_W-1:0] cur_in,
    input  logic [8*PIX_W-1:0] ref_in,
    output logic               need_cur,
    output logic               need_ref,
    output logic [3:0]         mv_x,
    output logic [3:0]         mv_y,
    output logic [SAD_W-1:0]   best_sad,
    output logic               done
);

`ifdef ME_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CUR,
        LOAD_REF,
        SEARCH,
        DONE
    } state_t;

    state_t state, nxt;

    logic [PIX_W-1:0] cur_m [8][8];
    logic [PIX_W-1:0] ref_m [16][16];

    logic             cur_d, ref_d;
    logic [3:0]       cw;
    logic [4:0]       rw;
    logic [5:0]       rq;
    logic [3:0]       dx, dy, bx, by;
    logic [2:0]       y;
    logic [3:0]       ry;
    logic [SAD_W-1:0] acc, best, row_sad, cand_sad;
    logic [PIX_W-1:0] ad [8];
    logic             row_end, last_cand, hit;

    assign ry = dy + {1'b0, y};

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            if (cur_m[y][3'(i)] > ref_m[ry][dx + 4'(i)])
                ad[i] = cur_m[y][3'(i)] - ref_m[ry][dx + 4'(i)];
            else
                ad[i] = ref_m[ry][dx + 4'(i)] - cur_m[y][3'(i)];
        end
    end

    always_comb begin
        row_sad = '0;
        for (int i = 0; i < 8; i++)
            row_sad = row_sad + SAD_W'(ad[i]);
    end

    assign cand_sad  = acc + row_sad;
    assign row_end   = (y == 3'd7);
    assign last_cand = (dx == 4'd8) && (dy == 4'd8);
    assign hit       = EARLY && (cand_sad == '0);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = LOAD_CUR;
            LOAD_CUR: if (rq == 6'd15) nxt = LOAD_REF;
            LOAD_REF: if (ref_d && rw == 5'd31) nxt = SEARCH;
            SEARCH:   if (row_end && (last_cand || hit)) nxt = DONE;
            DONE:     nxt = LOAD_CUR;
            default:  nxt = IDLE;
        endcase
    end

    // Requests are registered so they line up exactly with the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            need_cur <= 1'b0;
            need_ref <= 1'b0;
            cur_d    <= 1'b0;
            ref_d    <= 1'b0;
            cw       <= '0;
            rw       <= '0;
            rq       <= '0;
            dx       <= '0;
            dy       <= '0;
            y        <= '0;
            acc      <= '0;
            best     <= '0;
            bx       <= '0;
            by       <= '0;
            mv_x     <= '0;
            mv_y     <= '0;
            best_sad <= '0;
            done     <= 1'b0;
        end else begin
            need_cur <= (state == IDLE) || (state == DONE) ||
                        (state == LOAD_CUR && rq < 6'd15);
            need_ref <= (state == LOAD_CUR && rq == 6'd15) ||
                        (state == LOAD_REF && rq < 6'd31);
            cur_d    <= need_cur;
            ref_d    <= need_ref;
            done     <= (state == DONE);
            if (cur_d) cw <= cw + 4'd1;
            if (ref_d) rw <= rw + 5'd1;

            case (state)
                LOAD_CUR: rq <= (rq == 6'd15) ? '0 : rq + 6'd1;
                LOAD_REF: rq <= rq + 6'd1;
                default:  rq <= '0;
            endcase

            if (state == SEARCH) begin
                y <= y + 3'd1;
                if (row_end) begin
                    acc <= '0;
                    if ((dx == 4'd0 && dy == 4'd0) || cand_sad < best) begin
                        best <= cand_sad;
                        bx   <= dx;
                        by   <= dy;
                    end
                    if (dx == 4'd8) begin
                        dx <= '0;
                        dy <= dy + 4'd1;
                    end else begin
                        dx <= dx + 4'd1;
                    end
                end else begin
                    acc <= cand_sad;
                end
            end else begin
                y   <= '0;
                dx  <= '0;
                dy  <= '0;
                acc <= '0;
            end

            if (state == DONE) begin
                mv_x     <= bx - 4'd4;
                mv_y     <= by - 4'd4;
                best_sad <= best;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cur_d)
            for (int k = 0; k < 4; k++)
                cur_m[cw[3:1]][{cw[0], 2'(k)}] <= cur_in[PIX_W*k +: PIX_W];
        if (ref_d)
            for (int k = 0; k < 8; k++)
                ref_m[rw[4:1]][{rw[0], 3'(k)}] <= ref_in[PIX_W*k +: PIX_W];
    end

endmodule

// File: tb/tb_me_sad_engine.sv
// Self-checking bench for me_sad_engine: directed table plus random blocks
// checked against an exhaustive SAD reference model.
module tb_me_sad_engine;

    logic        clk;
    logic        rst;
    logic [31:0] cur_in;
    logic [63:0] ref_in;
    logic        need_cur, need_ref;
    logic [3:0]  mv_x, mv_y;
    logic [13:0] best_sad;
    logic        done;

    me_sad_engine dut (
        .clk(clk), .rst(rst), .cur_in(cur_in), .ref_in(ref_in),
        .need_cur(need_cur), .need_ref(need_ref),
        .mv_x(mv_x), .mv_y(mv_y), .best_sad(best_sad), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ME_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        int kind;
        int ex;
        int ey;
        int es;
        bit use_model;
    } vec_t;

    vec_t tab[7];

    int total = 0;
    int bad   = 0;
    int cur_img [8][8];
    int ref_img [16][16];
    int cyc = 0;
    int t_ref = 0;
    int done_cnt = 0;
    bit both_hi = 0;

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(string name, int act, int lo, int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Answers each request with the next word during the following cycle
    initial begin
        int ci, ri;
        bit pc, pr;
        logic [31:0] cw;
        logic [63:0] rw;
        ci = 0; ri = 0; pc = 0; pr = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ci = 0; ri = 0; pc = 0; pr = 0;
            end else begin
                if (pc) begin
                    for (int k = 0; k < 4; k++)
                        cw[8*k +: 8] = 8'(cur_img[ci >> 1][4*(ci & 1) + k]);
                    cur_in = cw;
                    ci = (ci + 1) % 16;
                end
                if (pr) begin
                    for (int k = 0; k < 8; k++)
                        rw[8*k +: 8] = 8'(ref_img[ri >> 1][8*(ri & 1) + k]);
                    ref_in = rw;
                    ri = (ri + 1) % 32;
                end
                pc = (need_cur === 1'b1);
                pr = (need_ref === 1'b1);
            end
        end
    end

    initial begin
        bit prev_r;
        prev_r = 0;
        forever begin
            @(negedge clk);
            if (need_cur === 1'b1 && need_ref === 1'b1) both_hi = 1;
            if (prev_r && need_ref === 1'b0) t_ref = cyc;
            if (done === 1'b1) done_cnt++;
            prev_r = (need_ref === 1'b1);
        end
    end

    task automatic set_images(int kind);
        int ox, oy, v;
        ox = $urandom_range(8);
        oy = $urandom_range(8);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                ref_img[r][c] = (kind >= 3) ? $urandom_range(255) : 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                case (kind)
                    0: cur_img[r][c] = r * 8 + c + 1;
                    1: cur_img[r][c] = 16;
                    2: cur_img[r][c] = 255;
                    3: cur_img[r][c] = ref_img[r][c];
                    4: begin
                        v = ref_img[oy + r][ox + c] + $urandom_range(3);
                        cur_img[r][c] = (v > 255) ? 255 : v;
                    end
                    default: cur_img[r][c] = $urandom_range(255);
                endcase
            end
        if (kind == 0)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    ref_img[2 + r][6 + c] = cur_img[r][c];
    endtask

    task automatic model(output int mx, output int my, output int ms, output int mk);
        int s, d;
        ms = 1 << 30; mx = 0; my = 0; mk = 0;
        for (int py = 0; py < 9; py++)
            for (int px = 0; px < 9; px++) begin
                s = 0;
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++) begin
                        d = cur_img[r][c] - ref_img[py + r][px + c];
                        s += (d < 0) ? -d : d;
                    end
                if (s < ms) begin
                    ms = s; mx = px - 4; my = py - 4; mk = py * 9 + px;
                end
            end
    endtask

    task automatic wait_done(output int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 3000);
        lat = cyc - t_ref;
        if (done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done, expected done within 3000 cycles");
            lat = -1;
        end
    endtask

    task automatic run_check(string tag, vec_t v);
        int mx, my, ms, mk, lat, lo, hi;
        model(mx, my, ms, mk);
        if (!v.use_model) begin
            mx = v.ex; my = v.ey; ms = v.es;
        end
        if (EARLY && ms == 0) begin
            lo = 8 * (mk + 1);
            hi = lo + 4;
        end else begin
            lo = 648;
            hi = 652;
        end
        wait_done(lat);
        check({tag, "_mv_x"}, int'($signed(mv_x)), mx);
        check({tag, "_mv_y"}, int'($signed(mv_y)), my);
        check({tag, "_sad"}, int'(best_sad), ms);
        check_rng({tag, "_latency"}, lat, lo, hi);
    endtask

    task automatic count_reqs(output int nc, output int nr);
        nc = 0;
        while (need_cur === 1'b1 && nc < 40) begin
            nc++;
            @(negedge clk);
        end
        nr = 0;
        while (need_ref === 1'b1 && nr < 40) begin
            nr++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n, nc, nr, dc;
        rst = 1'b1;
        cur_in = '0;
        ref_in = '0;
        tab[0] = '{0, 2, -2, 0, 1'b0};
        tab[1] = '{1, -4, -4, 1024, 1'b0};
        tab[2] = '{2, -4, -4, 16320, 1'b0};
        tab[3] = '{3, -4, -4, 0, 1'b0};
        tab[4] = '{4, 0, 0, 0, 1'b1};
        tab[5] = '{4, 0, 0, 0, 1'b1};
        tab[6] = '{5, 0, 0, 0, 1'b1};
        set_images(tab[0].kind);

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_outputs",
                  int'({need_cur, need_ref, done, mv_x, mv_y, best_sad}), 0);
        end
        rst = 1'b0;

        n = 0;
        while (need_cur !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        check("cur_start", n, 1);
        count_reqs(nc, nr);
        check("cur_len", nc, 16);
        check("ref_len", nr, 32);

        for (int i = 0; i < 7; i++) begin
            if (i > 0) set_images(tab[i].kind);
            run_check($sformatf("blk%0d", i), tab[i]);
        end

        n = 0;
        while (need_ref !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (need_ref !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (100) @(negedge clk);
        set_images(4);
        dc = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs",
              int'({need_cur, need_ref, done, mv_x, mv_y, best_sad}), 0);
        rst = 1'b0;
        n = 0;
        while (need_cur !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        check("midrst_cur_start", n, 1);
        count_reqs(nc, nr);
        check("midrst_cur_len", nc, 16);
        check("midrst_ref_len", nr, 32);
        check("midrst_no_done", done_cnt, dc);
        run_check("restart", '{4, 0, 0, 0, 1'b1});

        check("req_overlap", int'(both_hi), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
